// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding a DDS core: latches a sweep configuration on
// start and steps the frequency word in single, sawtooth-repeat or triangle mode.
module dds_sweep_ctrl #(
  parameter int PW = 32,
  parameter int CW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          abort,
  input  logic [PW-1:0] cfg_fstart,
  input  logic [PW-1:0] cfg_fstep,
  input  logic [CW-1:0] cfg_nsteps,
  input  logic [TW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic [PW-1:0] cfg_phase,
  output logic [PW-1:0] freq,
  output logic [PW-1:0] phase,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic [15:0]   seg_cnt
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [PW-1:0] fstart, fstep, fstart_n, fstep_n, freq_n, phase_n;
  logic [CW-1:0] nsteps, nsteps_n, idx, idx_n;
  logic [TW-1:0] dwell, dwell_n, dcnt, dcnt_n, dwell_last;
  logic [1:0]    mode, mode_n;
  logic          dir_up, dir_up_n, stop_seen, stop_seen_n;
  logic          en_n, busy_n, done_n;
  logic [15:0]   seg_cnt_n;
  logic          single_mode;

  // dwell of 0 behaves like 1: every cycle is a step event
  assign dwell_last  = (dwell == '0) ? '0 : dwell - TW'(1);
  assign single_mode = (mode == 2'd0) || (mode == 2'd3);

  always_comb begin
    state_n     = state;
    fstart_n    = fstart;
    fstep_n     = fstep;
    nsteps_n    = nsteps;
    dwell_n     = dwell;
    mode_n      = mode;
    freq_n      = freq;
    phase_n     = phase;
    idx_n       = idx;
    dcnt_n      = dcnt;
    dir_up_n    = dir_up;
    stop_seen_n = stop_seen;
    en_n        = en;
    busy_n      = busy;
    done_n      = 1'b0;
    seg_cnt_n   = seg_cnt;
    case (state)
      IDLE: if (start) begin
        fstart_n    = cfg_fstart;
        fstep_n     = cfg_fstep;
        nsteps_n    = cfg_nsteps;
        dwell_n     = cfg_dwell;
        mode_n      = cfg_mode;
        freq_n      = cfg_fstart;
        phase_n     = cfg_phase;
        idx_n       = '0;
        dcnt_n      = '0;
        dir_up_n    = 1'b1;
        stop_seen_n = 1'b0;
        seg_cnt_n   = '0;
        en_n        = 1'b1;
        busy_n      = 1'b1;
        state_n     = RUN;
      end
      RUN: if (abort) begin
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        stop_seen_n = stop_seen | stop;
        if (dcnt != dwell_last) begin
          dcnt_n = dcnt + TW'(1);
        end else begin
          dcnt_n = '0;
          if (idx < nsteps) begin
            freq_n = dir_up ? freq + fstep : freq - fstep;
            idx_n  = idx + CW'(1);
          end else begin
            seg_cnt_n = seg_cnt + 16'd1;
            if (single_mode || stop_seen || stop) begin
              en_n    = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = IDLE;
            end else if (mode == 2'd1) begin
              freq_n = fstart;
              idx_n  = '0;
            end else begin
              // triangle: turn around and take the first step of the new leg now,
              // so the peak/trough value is not held for an extra dwell
              dir_up_n = ~dir_up;
              if (nsteps != '0) begin
                freq_n = dir_up ? freq - fstep : freq + fstep;
                idx_n  = CW'(1);
              end else begin
                idx_n  = '0;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fstart    <= '0;
      fstep     <= '0;
      nsteps    <= '0;
      dwell     <= '0;
      mode      <= '0;
      freq      <= '0;
      phase     <= '0;
      idx       <= '0;
      dcnt      <= '0;
      dir_up    <= 1'b1;
      stop_seen <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_cnt   <= '0;
    end else begin
      state     <= state_n;
      fstart    <= fstart_n;
      fstep     <= fstep_n;
      nsteps    <= nsteps_n;
      dwell     <= dwell_n;
      mode      <= mode_n;
      freq      <= freq_n;
      phase     <= phase_n;
      idx       <= idx_n;
      dcnt      <= dcnt_n;
      dir_up    <= dir_up_n;
      stop_seen <= stop_seen_n;
      en        <= en_n;
      busy      <= busy_n;
      done      <= done_n;
      seg_cnt   <= seg_cnt_n;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected frequency words are queued when a
// sweep is launched and popped one per cycle while the sweep runs.
module tb_dds_sweep_ctrl;
  localparam int PW = 32, CW = 16, TW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, abort;
  logic [PW-1:0] cfg_fstart, cfg_fstep, cfg_phase;
  logic [CW-1:0] cfg_nsteps;
  logic [TW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] freq, phase;
  logic          en, busy, done;
  logic [15:0]   seg_cnt;

  int checks = 0;
  int fails  = 0;
  logic [PW-1:0] exp_q[$];

  dds_sweep_ctrl #(.PW(PW), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
    .cfg_fstart(cfg_fstart), .cfg_fstep(cfg_fstep), .cfg_nsteps(cfg_nsteps),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_phase(cfg_phase),
    .freq(freq), .phase(phase), .en(en), .busy(busy), .done(done), .seg_cnt(seg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // (n+1) values, each held max(dw,1) cycles: fs, fs+st, fs+2st, ...
  task automatic push_lin(input logic [PW-1:0] fs, input logic [PW-1:0] st,
                          input int n, input int dw);
    int d = (dw == 0) ? 1 : dw;
    for (int i = 0; i <= n; i++)
      for (int j = 0; j < d; j++)
        exp_q.push_back(fs + PW'(i) * st);
  endtask

  // Launch a sweep, then scramble cfg_* to show only the start cycle matters.
  task automatic launch(input logic [PW-1:0] fs, input logic [PW-1:0] st,
                        input int n, input int dw, input int md, input logic [PW-1:0] ph);
    cfg_fstart = fs; cfg_fstep = st; cfg_nsteps = CW'(n);
    cfg_dwell  = TW'(dw); cfg_mode = 2'(md); cfg_phase = ph;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_fstart = $urandom; cfg_fstep = $urandom; cfg_nsteps = CW'($urandom);
    cfg_dwell  = TW'($urandom); cfg_mode = 2'($urandom); cfg_phase = $urandom;
    chk("phase_latch", phase, ph);
  endtask

  // Drain the scoreboard one value per cycle; stop pulses on cycle stop_at.
  task automatic drain(input string tag, input int stop_at);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_freq"}, freq, exp_q.pop_front());
      chk({tag, "_en"}, {en, busy}, 2'b11);
      stop = (i == stop_at);
      tick();
      stop = 1'b0;
    end
  endtask

  task automatic check_end(input string tag, input logic [PW-1:0] last_f, input int segs);
    chk({tag, "_done"}, {done, en, busy}, 3'b100);
    chk({tag, "_seg"}, seg_cnt, segs);
    chk({tag, "_hold"}, freq, last_f);
    tick();
    chk({tag, "_done_pulse"}, {done, en}, 2'b00);
  endtask

  task automatic single_sweep(input string tag);
    push_lin(100, 10, 3, 2);
    launch(100, 10, 3, 2, 0, 32'h1234_5678);
    drain(tag, -1);
    check_end(tag, 130, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
    cfg_fstart = '0; cfg_fstep = '0; cfg_nsteps = '0; cfg_dwell = '0;
    cfg_mode = '0; cfg_phase = '0;
    tick(); tick();
    chk("reset_out", {freq, phase, en, busy, done, seg_cnt}, '0);
    rst = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort", {en, done}, 2'b00);

    single_sweep("single");

    // triangle, stop during third segment -> ends at its boundary
    foreach (exp_q[i]) ;
    exp_q.push_back(1000); exp_q.push_back(1005); exp_q.push_back(1010);
    exp_q.push_back(1005); exp_q.push_back(1000);
    exp_q.push_back(1005); exp_q.push_back(1010);
    launch(1000, 5, 2, 1, 2, 0);
    drain("tri", 5);
    check_end("tri", 1010, 3);

    // sawtooth with wrap, dwell 1 and dwell 0 must match
    for (int dw = 1; dw >= 0; dw--) begin
      push_lin(32'hFFFF_FFF0, 32'h10, 2, 1);
      push_lin(32'hFFFF_FFF0, 32'h10, 2, 1);
      launch(32'hFFFF_FFF0, 32'h10, 2, dw, 1, 7);
      drain(dw ? "saw1" : "saw0", 4);
      check_end(dw ? "saw1" : "saw0", 32'h10, 2);
    end

    // negative step
    push_lin(5, 32'hFFFF_FFFF, 5, 1);
    launch(5, 32'hFFFF_FFFF, 5, 1, 3, 0);
    drain("neg", -1);
    check_end("neg", 0, 1);

    // abort at cycle 3 of a dwell-4 sweep; simultaneous start ignored
    launch(100, 10, 3, 4, 0, 9);
    chk("abort_c1", freq, 100);
    tick();
    tick();
    chk("abort_c3", {en, freq}, {1'b1, 32'd100});
    abort = 1'b1; start = 1'b1;
    cfg_fstart = 777; cfg_mode = 2'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_done", {done, en, busy}, 3'b100);
    chk("abort_seg", seg_cnt, 0);
    tick();
    chk("abort_after", {done, en, busy, freq}, {3'b000, 32'd100});

    // reset mid-sweep: immediate clear, no done, no auto-restart
    launch(100, 10, 3, 2, 0, 32'hABCD);
    tick(); tick();
    #1 rst = 1'b0;
    #1 chk("rst_async", {freq, phase, en, busy, done, seg_cnt}, '0);
    tick();
    chk("rst_nodone", done, 0);
    rst = 1'b1;
    tick(); tick();
    chk("rst_idle", {en, busy, done}, 3'b000);
    single_sweep("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
